dm_arbiter: RTL and testbench

- Shares the single-port data memory (DM) between two requesters: master 0 is the CPU load/store port, master 1 is the debug/DMA port.
- Per-transaction request/grant handshake with round-robin arbitration.
- Sequences each access as accept, access, response.
- Checks op, alignment and range before asserting the DM write enable, and returns registered read data with a one-cycle valid pulse.

---
 rtl/dm_arbiter_if.sv | 31 +++
 rtl/dm_arbiter.sv | 148 ++++++++++++++
 tb/tb_dm_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Request/response bundle between one DM requester and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req is held with stable fields until gnt; rvalid is a one-cycle pulse with no ready.
//
// Signals:
//   req/we/addr/wdata/op  requester -> arbiter  access request and its fields
//   gnt                   arbiter -> requester  request accepted this cycle (combinational)
//   rvalid/rdata/err      arbiter -> requester  one-cycle response with load data / reject flag
interface dm_arbiter_if #(
  parameter int OP_W = 3
);
  logic            req;
  logic            we;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [OP_W-1:0] op;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;
  logic            err;

  modport master (
    output req, we, addr, wdata, op,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, op,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (m0) and debug/DMA (m1).
// Latency: gnt in T, DM access in T+1, rvalid in T+2; one access per 2 cycles sustained.
// Backpressure: requesters hold req until gnt; a new grant is only issued from IDLE or RESP.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   m0, m1             requester bundles (slave side), m0 = CPU load/store, m1 = debug/DMA
//   dm_we/dm_a/dm_wd/dm_op  DM write enable, address, write data, access code (0 outside ACCESS)
//   dm_rd              DM combinational read data, already extended by the DM
//   busy               high while an access is on the DM bus
module dm_arbiter #(
  parameter int unsigned DM_BYTES = 4096,
  parameter int          OP_W     = 3
) (
  input  logic            clk,
  input  logic            reset,
  dm_arbiter_if.slave     m0,
  dm_arbiter_if.slave     m1,
  output logic            dm_we,
  output logic [31:0]     dm_a,
  output logic [31:0]     dm_wd,
  output logic [OP_W-1:0] dm_op,
  input  logic [31:0]     dm_rd,
  output logic            busy
);

  localparam logic [OP_W-1:0] OP_WORD = OP_W'(3'b000);
  localparam logic [OP_W-1:0] OP_SB   = OP_W'(3'b001);
  localparam logic [OP_W-1:0] OP_UB   = OP_W'(3'b101);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // Fields of the accepted transaction, held for the ACCESS and RESP cycles.
  typedef struct packed {
    logic            id;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [OP_W-1:0] op;
  } xact_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_gnt;
  xact_t       r_xact;
  xact_t       w_xact_in;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_take;
  logic        w_sel;
  logic        w_op_ok;
  logic        w_misalign;
  logic        w_oor;
  logic        w_bad;
  logic        w_busy;

  // Next-state and grant selection.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_sel       = 1'b0;
    w_xact_in   = '0;

    case (r_state)
      S_IDLE, S_RESP: begin
        // Reset is folded in so gnt stays low while reset is held.
        if ((m0.req || m1.req) && !reset) begin
          w_take      = 1'b1;
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: w_state_nxt = S_RESP;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Contention goes to the master that did not win last; otherwise the sole requester wins.
    if (m0.req && m1.req) begin
      w_sel = ~r_last_gnt;
    end else begin
      w_sel = m1.req;
    end

    if (w_sel) begin
      w_xact_in = '{id: 1'b1, we: m1.we, addr: m1.addr, wdata: m1.wdata, op: m1.op};
    end else begin
      w_xact_in = '{id: 1'b0, we: m0.we, addr: m0.addr, wdata: m0.wdata, op: m0.op};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Rejection check on the latched fields.
  always_comb begin
    w_op_ok    = (r_xact.op == OP_WORD) || (r_xact.op == OP_SB) || (r_xact.op == OP_UB);
    w_misalign = (r_xact.op == OP_WORD) && (r_xact.addr[1:0] != 2'b00);
    w_oor      = (r_xact.addr >= 32'(DM_BYTES));
    w_bad      = !w_op_ok || w_misalign || w_oor;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // last_gnt = 1 gives m0 the first contended grant after reset.
      r_last_gnt <= 1'b1;
      r_xact     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_take) begin
        r_xact     <= w_xact_in;
        r_last_gnt <= w_sel;
      end
      if (r_state == S_ACCESS) begin
        r_rdata <= (r_xact.we || w_bad) ? 32'd0 : dm_rd;
        r_err   <= w_bad;
      end
    end
  end

  assign w_busy = (r_state == S_ACCESS);
  assign busy   = w_busy;
  assign dm_we  = w_busy && r_xact.we && !w_bad;
  assign dm_a   = w_busy ? r_xact.addr  : 32'd0;
  assign dm_wd  = w_busy ? r_xact.wdata : 32'd0;
  assign dm_op  = w_busy ? r_xact.op    : '0;

  assign m0.gnt    = w_take && !w_sel;
  assign m1.gnt    = w_take && w_sel;
  assign m0.rvalid = (r_state == S_RESP) && !r_xact.id;
  assign m1.rvalid = (r_state == S_RESP) && r_xact.id;
  assign m0.rdata  = r_rdata;
  assign m1.rdata  = r_rdata;
  assign m0.err    = r_err;
  assign m1.err    = r_err;

endmodule

// File: tb/tb_dm_arbiter.sv
`timescale 1ns/1ps
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        dm_we;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic [2:0]  dm_op;
  logic [31:0] dm_rd;
  logic        busy;

  always #5 clk = ~clk;

  dm_arbiter_if #(.OP_W(3)) m0_if ();
  dm_arbiter_if #(.OP_W(3)) m1_if ();

  dm_arbiter #(.DM_BYTES(4096), .OP_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .dm_we (dm_we),
    .dm_a  (dm_a),
    .dm_wd (dm_wd),
    .dm_op (dm_op),
    .dm_rd (dm_rd),
    .busy  (busy)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  op;
  } wr_t;

  resp_t q0[$];
  resp_t q1[$];
  wr_t   wq[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Byte-addressed DM model: word or byte access, extension done here as in the real DM.
  logic [7:0]  mem [0:4095];
  logic [11:0] dm_idx;
  assign dm_idx = dm_a[11:0];

  always_comb begin
    dm_rd = 32'd0;
    if (dm_a < 32'd4096) begin
      case (dm_op)
        3'b000:  dm_rd = {mem[dm_idx + 12'd3], mem[dm_idx + 12'd2], mem[dm_idx + 12'd1], mem[dm_idx]};
        3'b001:  dm_rd = {{24{mem[dm_idx][7]}}, mem[dm_idx]};
        3'b101:  dm_rd = {24'd0, mem[dm_idx]};
        default: dm_rd = 32'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (dm_we && dm_a < 32'd4096) begin
      if (dm_op == 3'b000) begin
        mem[dm_idx]         <= dm_wd[7:0];
        mem[dm_idx + 12'd1] <= dm_wd[15:8];
        mem[dm_idx + 12'd2] <= dm_wd[23:16];
        mem[dm_idx + 12'd3] <= dm_wd[31:24];
      end else begin
        mem[dm_idx] <= dm_wd[7:0];
      end
    end
  end

  // Monitor: pops expected writes/responses whenever the DUT presents them.
  resp_t mon_r;
  wr_t   mon_w;
  always @(negedge clk) begin
    if (!reset) begin
      if (m0_if.gnt || m1_if.gnt) chk("gnt_onehot", {31'd0, m0_if.gnt & m1_if.gnt}, 32'd0);
      if (dm_we) begin
        if (wq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_dm_write: got dm_a=0x%08h dm_wd=0x%08h, expected no write", dm_a, dm_wd);
        end else begin
          mon_w = wq.pop_front();
          chk("dm_write_cycle", 32'(cyc), 32'(mon_w.cyc));
          chk("dm_a", dm_a, mon_w.a);
          chk("dm_wd", dm_wd, mon_w.wd);
          chk("dm_op", {29'd0, dm_op}, {29'd0, mon_w.op});
        end
      end
      if (m0_if.rvalid) begin
        if (q0.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_m0_rvalid: got rvalid at cycle %0d, expected none", cyc);
        end else begin
          mon_r = q0.pop_front();
          chk("m0_rvalid_cycle", 32'(cyc), 32'(mon_r.cyc));
          chk("m0_rdata", m0_if.rdata, mon_r.rdata);
          chk("m0_err", {31'd0, m0_if.err}, {31'd0, mon_r.err});
        end
      end
      if (m1_if.rvalid) begin
        if (q1.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_m1_rvalid: got rvalid at cycle %0d, expected none", cyc);
        end else begin
          mon_r = q1.pop_front();
          chk("m1_rvalid_cycle", 32'(cyc), 32'(mon_r.cyc));
          chk("m1_rdata", m1_if.rdata, mon_r.rdata);
          chk("m1_err", {31'd0, m1_if.err}, {31'd0, mon_r.err});
        end
      end
    end
  end

  // Issue one request from master m, wait for its grant, then push the expected outcome.
  task automatic issue(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] op, input logic [31:0] exp_rd, input logic exp_err,
                       output int gcyc);
    resp_t r;
    wr_t   w;
    int    waited;
    if (m == 0) begin
      m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.op = op; m0_if.req = 1'b1;
    end else begin
      m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.op = op; m1_if.req = 1'b1;
    end
    waited = 0;
    gcyc   = -1;
    while (gcyc < 0 && waited < 50) begin
      @(negedge clk);
      if ((m == 0 && m0_if.gnt) || (m == 1 && m1_if.gnt)) gcyc = cyc;
      else waited++;
    end
    if (gcyc < 0) begin
      n_checks++;
      $display("FAIL grant_timeout_m%0d: got no gnt in 50 cycles, expected gnt", m);
    end else begin
      r.cyc = gcyc + 2; r.rdata = exp_rd; r.err = exp_err;
      if (m == 0) q0.push_back(r); else q1.push_back(r);
      if (we && !exp_err) begin
        w.cyc = gcyc + 1; w.a = addr; w.wd = wdata; w.op = op;
        wq.push_back(w);
      end
    end
    @(posedge clk); #1;
    if (m == 0) m0_if.req = 1'b0; else m1_if.req = 1'b0;
  endtask

  int g0a, g0b, g0c, g1a, g1b, s, waited;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.addr = 32'h10; m0_if.wdata = 32'h1; m0_if.op = 3'b000;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = 32'h0;  m1_if.wdata = 32'h0; m1_if.op = 3'b000;
    reset = 1'b1;

    // Reset state: all outputs 0 even with a request pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m0_gnt", {31'd0, m0_if.gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_if.gnt}, 32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd0);
    chk("rst_rdata", m0_if.rdata, 32'd0);
    chk("rst_err", {31'd0, m0_if.err}, 32'd0);
    chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_dm_a", dm_a, 32'd0);
    chk("rst_dm_wd", dm_wd, 32'd0);
    chk("rst_dm_op", {29'd0, dm_op}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    m0_if.req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Word store then load back.
    s = cyc;
    issue(0, 1'b1, 32'h10, 32'h12345678, 3'b000, 32'h0, 1'b0, g0a);
    chk("t1_gnt_cycle", 32'(g0a - s), 32'd0);
    issue(0, 1'b0, 32'h10, 32'h0, 3'b000, 32'h12345678, 1'b0, g0b);
    chk("t1_load_gnt_in_resp", 32'(g0b - g0a), 32'd2);

    // Byte store, then signed and unsigned byte loads.
    issue(0, 1'b1, 32'h13, 32'h00000080, 3'b001, 32'h0, 1'b0, g0a);
    issue(0, 1'b0, 32'h13, 32'h0, 3'b001, 32'hFFFFFF80, 1'b0, g0a);
    issue(0, 1'b0, 32'h13, 32'h0, 3'b101, 32'h00000080, 1'b0, g0a);

    // Rejected accesses: misaligned word store, illegal op, out of range.
    issue(1, 1'b1, 32'h6,    32'hAAAA5555, 3'b000, 32'h0, 1'b1, g1a);
    issue(1, 1'b0, 32'h0,    32'h0,        3'b010, 32'h0, 1'b1, g1a);
    issue(1, 1'b1, 32'h1000, 32'hCAFEF00D, 3'b000, 32'h0, 1'b1, g1a);
    repeat (3) @(posedge clk); #1;

    // Continuous contention: grants alternate m0, m1, m0, m1 every 2 cycles.
    fork
      begin
        issue(0, 1'b0, 32'h10, 32'h0, 3'b000, 32'h80345678, 1'b0, g0a);
        issue(0, 1'b0, 32'h10, 32'h0, 3'b001, 32'h00000078, 1'b0, g0b);
      end
      begin
        issue(1, 1'b0, 32'h13, 32'h0, 3'b101, 32'h00000080, 1'b0, g1a);
        issue(1, 1'b0, 32'h12, 32'h0, 3'b001, 32'h00000034, 1'b0, g1b);
      end
    join
    chk("rr_m1_first", 32'(g1a - g0a), 32'd2);
    chk("rr_m0_second", 32'(g0b - g0a), 32'd4);
    chk("rr_m1_second", 32'(g1b - g0a), 32'd6);
    repeat (3) @(posedge clk); #1;

    // m1 waits while m0 streams: m1 gets the slot in RESP of m0's first access.
    fork
      begin
        issue(0, 1'b0, 32'h10, 32'h0, 3'b000, 32'h80345678, 1'b0, g0a);
        issue(0, 1'b0, 32'h10, 32'h0, 3'b000, 32'h80345678, 1'b0, g0b);
        issue(0, 1'b0, 32'h10, 32'h0, 3'b000, 32'h80345678, 1'b0, g0c);
      end
      begin
        @(posedge clk); #2;
        issue(1, 1'b0, 32'h11, 32'h0, 3'b101, 32'h00000056, 1'b0, g1a);
      end
    join
    chk("starve_m1_gnt", 32'(g1a - g0a), 32'd2);
    chk("starve_m0_after", 32'(g0b - g0a), 32'd4);
    chk("starve_m0_third", 32'(g0c - g0a), 32'd6);
    repeat (3) @(posedge clk); #1;

    // Reset during ACCESS of a store: dropped, no write, no rvalid.
    m0_if.we = 1'b1; m0_if.addr = 32'h20; m0_if.wdata = 32'hDEADBEEF; m0_if.op = 3'b000; m0_if.req = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!m0_if.gnt && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("rst_mid_gnt", {31'd0, m0_if.gnt}, 32'd1);
    @(posedge clk); #1;
    m0_if.req = 1'b0;
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_dm_a", dm_a, 32'd0);
    chk("rst_mid_dm_wd", dm_wd, 32'd0);
    chk("rst_mid_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    // After reset m0 wins contention; the aborted store left 0x20 untouched.
    fork
      issue(0, 1'b0, 32'h20, 32'h0, 3'b000, 32'h00000000, 1'b0, g0a);
      issue(1, 1'b0, 32'h10, 32'h0, 3'b000, 32'h80345678, 1'b0, g1a);
    join
    chk("post_rst_m0_first", 32'(g1a - g0a), 32'd2);

    waited = 0;
    while ((q0.size() != 0 || q1.size() != 0 || wq.size() != 0) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk("drain_wq", 32'(wq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
